// File: rtl/bexkat2_intctrl.sv
// bexkat2_intctrl: eight-source interrupt controller for the bexkat2 CPU.
//
// Wishbone classic responder on the CPU data bus plus the source end of the
// CPU exception-request handshake.  Raw interrupt lines are synchronized,
// captured as edge- or level-type pending bits, masked by ENABLE, and the
// lowest-numbered request is presented as irq_o/vec_o until the CPU accepts
// it with ack_i.  Software retires the interrupt with a write to STATUS (EOI).
//
// Register map (word address adr_i, reads zero-extended to 32 bits):
//   0 PENDING  read pending[7:0]; write-1-to-clear (edge sources only)
//   1 ENABLE   read/write
//   2 EDGE     read/write, 1 = edge-triggered, 0 = level
//   3 STATUS   read {state[1:0] @5:4, 0 @3, vec @2:0}; any write is an EOI
//
// Ports:
//   clk_i      system clock
//   rst_i      asynchronous active-low reset
//   cyc_i, stb_i, we_i, adr_i[1:0], sel_i[3:0], dat_i[31:0]  bus inputs
//   dat_o[31:0], ack_o                                       bus outputs
//   irq_src_i[7:0]  raw interrupt lines, asynchronous to clk_i
//   irq_o, vec_o[2:0]  request and vector to the CPU
//   ack_i      one-cycle acceptance pulse from the CPU

module bexkat2_intctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [1:0]  adr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    input  logic [7:0]  irq_src_i,
    output logic        irq_o,
    output logic [2:0]  vec_o,
    input  logic        ack_i
);

    localparam int NSRC = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [2:0]        vec_r;
    logic [2:0]        vec_s;
    logic              irq_r;
    logic              ack_r;
    logic [31:0]       dat_r;
    logic [NSRC-1:0]   s1_r;
    logic [NSRC-1:0]   s2_r;
    logic [NSRC-1:0]   s3_r;
    logic [NSRC-1:0]   pending_r;
    logic [NSRC-1:0]   pending_s;
    logic [NSRC-1:0]   enable_r;
    logic [NSRC-1:0]   edge_r;
    logic [NSRC-1:0]   edge_det_s;
    logic [NSRC-1:0]   req_s;
    logic [NSRC-1:0]   w1c_s;
    logic [NSRC-1:0]   ack_clr_s;
    logic [31:0]       rd_data_s;
    logic              access_s;
    logic              wr_s;
    logic              wr_byte0_s;
    logic              eoi_s;
    logic              unused_s;

    // Lowest-numbered set bit wins; returns 0 for an empty set.
    function automatic logic [2:0] lowest_idx(input logic [NSRC-1:0] req);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Only byte lane 0 carries register data.
    assign unused_s = ^{sel_i[3:1], dat_i[31:8]};

    // A strobe is serviced only on cycles where no ack is being returned,
    // which is what makes a held strobe ack on alternate cycles.
    assign access_s   = cyc_i & stb_i & ~ack_r;
    assign wr_s       = access_s & we_i;
    assign wr_byte0_s = wr_s & sel_i[0];
    assign eoi_s      = wr_s & (adr_i == 2'd3);

    assign edge_det_s = s2_r & ~s3_r;
    assign req_s      = pending_r & enable_r;

    // Pending next-state: edge bits set-dominant over W1C/ack clear, level bits follow s2.
    always_comb begin
        w1c_s     = {NSRC{1'b0}};
        ack_clr_s = {NSRC{1'b0}};
        if (wr_byte0_s && (adr_i == 2'd0)) begin
            w1c_s = dat_i[NSRC-1:0];
        end else begin
            w1c_s = {NSRC{1'b0}};
        end
        if ((state_r == ST_REQ) && ack_i) begin
            ack_clr_s = 8'd1 << vec_r;
        end else begin
            ack_clr_s = {NSRC{1'b0}};
        end
        pending_s = (edge_r & ((pending_r & ~(w1c_s | ack_clr_s)) | edge_det_s))
                  | (~edge_r & s2_r);
    end

    // Request state machine next-state; vec is frozen once a request is raised.
    always_comb begin
        state_s = state_r;
        vec_s   = vec_r;
        case (state_r)
            ST_IDLE: begin
                if (|req_s) begin
                    state_s = ST_REQ;
                    vec_s   = lowest_idx(req_s);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_i) begin
                    state_s = ST_SERVICE;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (eoi_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SERVICE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                vec_s   = 3'd0;
            end
        endcase
    end

    // Register read multiplexer.
    always_comb begin
        rd_data_s = 32'd0;
        case (adr_i)
            2'd0:    rd_data_s = {24'd0, pending_r};
            2'd1:    rd_data_s = {24'd0, enable_r};
            2'd2:    rd_data_s = {24'd0, edge_r};
            2'd3:    rd_data_s = {26'd0, state_r, 1'b0, vec_r};
            default: rd_data_s = 32'd0;
        endcase
    end

    // Synchronizer chain, with s3 kept as edge-detect history.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_r <= {NSRC{1'b0}};
            s2_r <= {NSRC{1'b0}};
            s3_r <= {NSRC{1'b0}};
        end else begin
            s1_r <= irq_src_i;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Configuration and pending registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pending_r <= {NSRC{1'b0}};
            enable_r  <= {NSRC{1'b0}};
            edge_r    <= {NSRC{1'b0}};
        end else begin
            pending_r <= pending_s;
            if (wr_byte0_s && (adr_i == 2'd1)) begin
                enable_r <= dat_i[NSRC-1:0];
            end
            if (wr_byte0_s && (adr_i == 2'd2)) begin
                edge_r <= dat_i[NSRC-1:0];
            end
        end
    end

    // State machine registers and the registered request output.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_IDLE;
            vec_r   <= 3'd0;
            irq_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            vec_r   <= vec_s;
            irq_r   <= (state_s == ST_REQ);
        end
    end

    // Bus acknowledge and registered read data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_r <= 1'b0;
            dat_r <= 32'd0;
        end else begin
            ack_r <= access_s;
            if (access_s) begin
                dat_r <= rd_data_s;
            end
        end
    end

    assign ack_o = ack_r;
    assign dat_o = dat_r;
    assign irq_o = irq_r;
    assign vec_o = vec_r;

endmodule

// File: tb/tb_bexkat2_intctrl.sv
// Directed self-checking bench for bexkat2_intctrl.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.

`timescale 1ns/1ps

module tb_bexkat2_intctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        we_i  = 1'b0;
    logic [1:0]  adr_i = 2'd0;
    logic [3:0]  sel_i = 4'h0;
    logic [31:0] dat_i = 32'd0;
    logic [31:0] dat_o;
    logic        ack_o;
    logic [7:0]  irq_src_i = 8'h00;
    logic        irq_o;
    logic [2:0]  vec_o;
    logic        ack_i = 1'b0;

    int checks   = 0;
    int failures = 0;

    bexkat2_intctrl dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cyc_i     (cyc_i),
        .stb_i     (stb_i),
        .we_i      (we_i),
        .adr_i     (adr_i),
        .sel_i     (sel_i),
        .dat_i     (dat_i),
        .dat_o     (dat_o),
        .ack_o     (ack_o),
        .irq_src_i (irq_src_i),
        .irq_o     (irq_o),
        .vec_o     (vec_o),
        .ack_i     (ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
    endtask

    // Returns 1 time unit after the edge that performed the access.
    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        logic ok;
        ok = 1'b0;
        d  = 32'd0;
        if (ack_o) tick();
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = a; sel_i = 4'hF;
        for (int i = 0; i < 4 && !ok; i++) begin
            tick();
            if (ack_o) begin
                ok = 1'b1;
                d  = dat_o;
            end
        end
        cyc_i = 1'b0; stb_i = 1'b0;
        if (!ok) check_eq("rd_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        logic ok;
        ok = 1'b0;
        if (ack_o) tick();
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = a; sel_i = s; dat_i = d;
        for (int i = 0; i < 4 && !ok; i++) begin
            tick();
            if (ack_o) ok = 1'b1;
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        if (!ok) check_eq("wr_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic cpu_ack();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
    endtask

    logic [31:0] rd;
    logic        seen;

    initial begin
        // Reset with all sources high.
        irq_src_i = 8'hFF;
        #1 rst_i = 1'b0;
        #2;
        check_eq("rst_irq", {31'd0, irq_o}, 32'd0);
        check_eq("rst_vec", {29'd0, vec_o}, 32'd0);
        check_eq("rst_ack", {31'd0, ack_o}, 32'd0);
        check_eq("rst_dat", dat_o, 32'd0);
        tick();
        rst_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (irq_o) seen = 1'b1;
        end
        check_eq("disabled_no_irq", {31'd0, seen}, 32'd0);
        bus_read(2'd0, rd);
        check_eq("level_pending_ff", rd, 32'h0000_00FF);
        bus_read(2'd3, rd);
        check_eq("status_idle", rd, 32'h0000_0000);

        // Edge mode, single-cycle pulse on source 2.
        irq_src_i = 8'h00;
        do_reset();
        bus_write(2'd2, 32'h0000_00FF, 4'h1);
        bus_write(2'd1, 32'h0000_0004, 4'h1);
        tick();
        irq_src_i = 8'h04;
        tick();                        // edge 1
        irq_src_i = 8'h00;
        tick();                        // edge 2
        tick();                        // edge 3
        check_eq("edge_irq_e3", {31'd0, irq_o}, 32'd0);
        tick();                        // edge 4
        check_eq("edge_irq_e4", {31'd0, irq_o}, 32'd1);
        check_eq("edge_vec", {29'd0, vec_o}, 32'd2);
        cpu_ack();
        check_eq("edge_irq_after_ack", {31'd0, irq_o}, 32'd0);
        bus_read(2'd0, rd);
        check_eq("edge_pending_cleared", rd, 32'h0000_0000);
        bus_read(2'd3, rd);
        check_eq("status_service", rd, 32'h0000_0022);
        bus_write(2'd3, 32'h0000_0000, 4'h0);   // EOI regardless of sel
        bus_read(2'd3, rd);
        check_eq("status_after_eoi", rd, 32'h0000_0002);

        // Priority: sources 5 and 1 together.
        do_reset();
        bus_write(2'd2, 32'h0000_00FF, 4'h1);
        bus_write(2'd1, 32'h0000_00FF, 4'h1);
        tick();
        irq_src_i = 8'h22;
        for (int i = 0; i < 4; i++) tick();
        check_eq("prio_irq", {31'd0, irq_o}, 32'd1);
        check_eq("prio_vec_first", {29'd0, vec_o}, 32'd1);
        cpu_ack();
        bus_write(2'd3, 32'h0000_0000, 4'h1);
        tick();
        check_eq("prio_irq_second", {31'd0, irq_o}, 32'd1);
        check_eq("prio_vec_second", {29'd0, vec_o}, 32'd5);
        cpu_ack();
        bus_write(2'd3, 32'h0000_0000, 4'h1);
        irq_src_i = 8'h00;

        // W1C against a new edge on the same bit in the same cycle.
        do_reset();
        bus_write(2'd2, 32'h0000_00FF, 4'h1);
        tick();
        irq_src_i = 8'h08;
        tick();                        // edge 1
        tick();                        // edge 2
        bus_write(2'd0, 32'h0000_0008, 4'h1);   // lands on edge 3 with the set
        bus_read(2'd0, rd);
        check_eq("w1c_set_wins", rd, 32'h0000_0008);
        bus_write(2'd0, 32'h0000_0008, 4'h0);
        bus_read(2'd0, rd);
        check_eq("w1c_sel0_ignored", rd, 32'h0000_0008);
        bus_write(2'd0, 32'h0000_0008, 4'h1);
        bus_read(2'd0, rd);
        check_eq("w1c_clears", rd, 32'h0000_0000);
        irq_src_i = 8'h00;

        // Held-strobe read of ENABLE: ack pattern 0,1,0,1.
        bus_write(2'd1, 32'h0000_00A5, 4'h1);
        tick();
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 2'd1; sel_i = 4'hF;
        check_eq("held_ack0", {31'd0, ack_o}, 32'd0);
        tick();
        check_eq("held_ack1", {31'd0, ack_o}, 32'd1);
        check_eq("held_dat1", dat_o, 32'h0000_00A5);
        tick();
        check_eq("held_ack2", {31'd0, ack_o}, 32'd0);
        tick();
        check_eq("held_ack3", {31'd0, ack_o}, 32'd1);
        check_eq("held_dat3", dat_o, 32'h0000_00A5);
        cyc_i = 1'b0; stb_i = 1'b0;
        tick();

        // Level source held high re-requests after EOI.
        do_reset();
        bus_write(2'd1, 32'h0000_0001, 4'h1);
        tick();
        irq_src_i = 8'h01;
        for (int i = 0; i < 4; i++) tick();
        check_eq("level_irq", {31'd0, irq_o}, 32'd1);
        check_eq("level_vec", {29'd0, vec_o}, 32'd0);
        cpu_ack();
        check_eq("level_irq_acked", {31'd0, irq_o}, 32'd0);
        bus_write(2'd3, 32'h0000_0000, 4'h1);
        check_eq("level_irq_at_eoi", {31'd0, irq_o}, 32'd0);
        tick();
        check_eq("level_rerequest", {31'd0, irq_o}, 32'd1);

        // Asynchronous reset while in REQ.
        rst_i = 1'b0;
        #2;
        check_eq("async_rst_irq", {31'd0, irq_o}, 32'd0);
        check_eq("async_rst_vec", {29'd0, vec_o}, 32'd0);
        tick();
        rst_i = 1'b1;
        irq_src_i = 8'h00;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
